// File: rtl/cache_pkg.sv
// Shared definitions for the cache block-fill controller: FSM states,
// default block geometry and bus address helpers.
package cache_pkg;

  localparam int BLOCKSIZE_DEF = 4;
  localparam int CW_DEF        = 2;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    FETCH     = 2'd2,
    DONE      = 2'd3
  } fill_state_t;

  // Word-aligned address of one beat inside a 16-byte block.
  function automatic logic [31:0] beat_addr(input logic [27:0] blk,
                                            input logic [31:0] word_idx);
    return {blk, 4'b0000} | (word_idx << 2);
  endfunction

  // Request address forced to word alignment.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/block_word_counter.sv
// Word index within a cache block. Clears synchronously, advances on
// enable and wraps modulo BLOCKSIZE; 'wrap' flags the final beat.
import cache_pkg::*;

module block_word_counter #(
  parameter int BLOCKSIZE = BLOCKSIZE_DEF,
  parameter int CW        = CW_DEF
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clear,
  input  logic          en,
  output logic [CW-1:0] count,
  output logic          wrap
);

  localparam logic [CW-1:0] LAST = CW'(BLOCKSIZE - 1);

  // Final beat of the block completes this cycle.
  assign wrap = en && (count == LAST);

  // Counter register: clear dominates, then advance with explicit wrap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en) begin
      if (count == LAST) count <= '0;
      else               count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/cache_fill_ctrl.sv
// Cache miss handler: optional dirty-victim writeback, block fetch over
// the bus one word per HREADY beat, then a single DONE cycle so the
// pipeline can re-read tag and data before releasing the stall.
import cache_pkg::*;

module cache_fill_ctrl #(
  parameter int BLOCKSIZE = BLOCKSIZE_DEF,
  parameter int CW        = CW_DEF
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          MemRE,
  input  logic          MemWriteM,
  input  logic          Hit,
  input  logic          Dirty,
  input  logic [31:0]   A,
  input  logic [27:0]   VictimA,
  input  logic          HREADY,
  output logic          HRequest,
  output logic          HWrite,
  output logic [31:0]   HAddr,
  output logic          BlockWE,
  output logic [CW-1:0] Counter,
  output logic          Stall
);

  fill_state_t state;
  logic        miss;
  logic        busy;
  logic        cnt_en;
  logic        cnt_clear;
  logic        last_beat;

  assign miss      = (MemRE | MemWriteM) & ~Hit;
  assign busy      = (state == WRITEBACK) || (state == FETCH);
  assign cnt_en    = busy && HREADY;
  assign cnt_clear = (state == IDLE) || (state == DONE);

  block_word_counter #(
    .BLOCKSIZE (BLOCKSIZE),
    .CW        (CW)
  ) u_word_counter (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (cnt_clear),
    .en      (cnt_en),
    .count   (Counter),
    .wrap    (last_beat)
  );

  // State register: request inputs only matter in IDLE; the bus phases
  // advance on the final HREADY beat of the block.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (miss) state <= Dirty ? WRITEBACK : FETCH;
        end
        WRITEBACK: begin
          if (last_beat) state <= FETCH;
        end
        FETCH: begin
          if (last_beat) state <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Bus and pipeline outputs decoded from state; Stall is masked while
  // reset is held because the IDLE term still follows the live miss.
  always_comb begin
    HRequest = 1'b0;
    HWrite   = 1'b0;
    BlockWE  = 1'b0;
    HAddr    = word_align(A);
    Stall    = 1'b1;
    unique case (state)
      IDLE: begin
        Stall = miss & reset_n;
      end
      WRITEBACK: begin
        HRequest = 1'b1;
        HWrite   = 1'b1;
        HAddr    = beat_addr(VictimA, 32'(Counter));
      end
      FETCH: begin
        HRequest = 1'b1;
        BlockWE  = HREADY;
        HAddr    = beat_addr(A[31:4], 32'(Counter));
      end
      DONE: begin
        Stall = 1'b1;
      end
      default: begin
        Stall = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Directed testbench for cache_fill_ctrl: reset, clean miss, dirty miss,
// wait states, reset during fetch and write hit.
module tb_cache_fill_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        MemRE, MemWriteM, Hit, Dirty, HREADY;
  logic [31:0] A;
  logic [27:0] VictimA;
  logic        HRequest, HWrite, BlockWE, Stall;
  logic [31:0] HAddr;
  logic [1:0]  Counter;

  int tests = 0;
  int fails = 0;

  cache_fill_ctrl #(.BLOCKSIZE(4), .CW(2)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .MemRE     (MemRE),
    .MemWriteM (MemWriteM),
    .Hit       (Hit),
    .Dirty     (Dirty),
    .A         (A),
    .VictimA   (VictimA),
    .HREADY    (HREADY),
    .HRequest  (HRequest),
    .HWrite    (HWrite),
    .HAddr     (HAddr),
    .BlockWE   (BlockWE),
    .Counter   (Counter),
    .Stall     (Stall)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    reset_n = 1'b0; MemRE = 1'b1; MemWriteM = 1'b0; Hit = 1'b0; Dirty = 1'b0;
    A = 32'h0; VictimA = 28'h0; HREADY = 1'b1;
    @(negedge clk); #1;
    tests++; if (HRequest !== 1'b0) begin fails++; $display("FAIL rst_hreq got %b want 0", HRequest); end
    tests++; if (Stall !== 1'b0) begin fails++; $display("FAIL rst_stall got %b want 0", Stall); end
    tests++; if (Counter !== 2'd0) begin fails++; $display("FAIL rst_counter got %0d want 0", Counter); end
    tests++; if (BlockWE !== 1'b0 || HWrite !== 1'b0) begin fails++; $display("FAIL rst_we got %b%b want 00", BlockWE, HWrite); end
    @(negedge clk); MemRE = 1'b0; reset_n = 1'b1;
  endtask

  task automatic test_clean_miss();
    int stalls = 0;
    @(negedge clk); MemRE = 1'b1; Hit = 1'b0; Dirty = 1'b0; A = 32'h0000_1234; HREADY = 1'b1; #1;
    tests++; if (Stall !== 1'b1 || HRequest !== 1'b0) begin fails++; $display("FAIL clean_idle got stall=%b hreq=%b want 1 0", Stall, HRequest); end
    tests++; if (HAddr !== 32'h1234) begin fails++; $display("FAIL clean_idle_addr got %h want 00001234", HAddr); end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
      if (Stall === 1'b1) stalls++;
      tests++;
      if (HRequest !== 1'b1 || HWrite !== 1'b0 || BlockWE !== 1'b1 || Counter !== 2'(k) || HAddr !== 32'h1230 + 32'(4*k)) begin
        fails++; $display("FAIL clean_fetch%0d got req=%b wr=%b we=%b cnt=%0d addr=%h want 1 0 1 %0d %h",
                          k, HRequest, HWrite, BlockWE, Counter, HAddr, k, 32'h1230 + 32'(4*k));
      end
    end
    @(negedge clk); Hit = 1'b1; #1;
    if (Stall === 1'b1) stalls++;
    tests++; if (HRequest !== 1'b0 || BlockWE !== 1'b0 || Counter !== 2'd0 || HAddr !== 32'h1234) begin
      fails++; $display("FAIL clean_done got req=%b we=%b cnt=%0d addr=%h want 0 0 0 00001234", HRequest, BlockWE, Counter, HAddr); end
    tests++; if (stalls != 5) begin fails++; $display("FAIL clean_stall_cycles got %0d want 5", stalls); end
    @(negedge clk); #1;
    tests++; if (Stall !== 1'b0 || HRequest !== 1'b0) begin fails++; $display("FAIL clean_back_idle got stall=%b hreq=%b want 0 0", Stall, HRequest); end
    MemRE = 1'b0;
  endtask

  task automatic test_dirty_miss();
    int stalls = 0;
    @(negedge clk); MemRE = 1'b1; Hit = 1'b0; Dirty = 1'b1; A = 32'h0000_2000; VictimA = 28'h0000ABC; HREADY = 1'b1; #1;
    tests++; if (Stall !== 1'b1 || HRequest !== 1'b0) begin fails++; $display("FAIL dirty_idle got stall=%b hreq=%b want 1 0", Stall, HRequest); end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
      if (Stall === 1'b1) stalls++;
      tests++;
      if (HRequest !== 1'b1 || HWrite !== 1'b1 || BlockWE !== 1'b0 || Counter !== 2'(k) || HAddr !== 32'hABC0 + 32'(4*k)) begin
        fails++; $display("FAIL dirty_wb%0d got req=%b wr=%b we=%b cnt=%0d addr=%h want 1 1 0 %0d %h",
                          k, HRequest, HWrite, BlockWE, Counter, HAddr, k, 32'hABC0 + 32'(4*k));
      end
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 1) begin Hit = 1'b1; Dirty = 1'b0; end
      #1;
      if (Stall === 1'b1) stalls++;
      tests++;
      if (HRequest !== 1'b1 || HWrite !== 1'b0 || BlockWE !== 1'b1 || Counter !== 2'(k) || HAddr !== 32'h2000 + 32'(4*k)) begin
        fails++; $display("FAIL dirty_fetch%0d got req=%b wr=%b we=%b cnt=%0d addr=%h want 1 0 1 %0d %h",
                          k, HRequest, HWrite, BlockWE, Counter, HAddr, k, 32'h2000 + 32'(4*k));
      end
    end
    @(negedge clk); #1;
    if (Stall === 1'b1) stalls++;
    tests++; if (HRequest !== 1'b0 || Stall !== 1'b1) begin fails++; $display("FAIL dirty_done got req=%b stall=%b want 0 1", HRequest, Stall); end
    tests++; if (stalls != 9) begin fails++; $display("FAIL dirty_stall_cycles got %0d want 9", stalls); end
    @(negedge clk); #1;
    tests++; if (Stall !== 1'b0 || HRequest !== 1'b0) begin fails++; $display("FAIL dirty_back_idle got stall=%b hreq=%b want 0 0", Stall, HRequest); end
    MemRE = 1'b0;
  endtask

  task automatic test_wait_states();
    @(negedge clk); MemRE = 1'b1; Hit = 1'b0; Dirty = 1'b0; A = 32'h0000_3000; HREADY = 1'b1;
    @(negedge clk); Dirty = 1'b1; #1;
    tests++; if (Counter !== 2'd0 || HWrite !== 1'b0 || HAddr !== 32'h3000) begin fails++; $display("FAIL wait_w0 got cnt=%0d wr=%b addr=%h want 0 0 00003000", Counter, HWrite, HAddr); end
    @(negedge clk); #1;
    tests++; if (Counter !== 2'd1) begin fails++; $display("FAIL wait_w1 got cnt=%0d want 1", Counter); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); HREADY = 1'b0; #1;
      tests++;
      if (Counter !== 2'd2 || BlockWE !== 1'b0 || HRequest !== 1'b1 || HAddr !== 32'h3008) begin
        fails++; $display("FAIL wait_hold%0d got cnt=%0d we=%b req=%b addr=%h want 2 0 1 00003008", k, Counter, BlockWE, HRequest, HAddr);
      end
    end
    @(negedge clk); HREADY = 1'b1; #1;
    tests++; if (Counter !== 2'd2 || BlockWE !== 1'b1 || HAddr !== 32'h3008) begin fails++; $display("FAIL wait_w2 got cnt=%0d we=%b addr=%h want 2 1 00003008", Counter, BlockWE, HAddr); end
    @(negedge clk); #1;
    tests++; if (Counter !== 2'd3 || BlockWE !== 1'b1 || HAddr !== 32'h300C) begin fails++; $display("FAIL wait_w3 got cnt=%0d we=%b addr=%h want 3 1 0000300c", Counter, BlockWE, HAddr); end
    @(negedge clk); #1;
    tests++; if (HRequest !== 1'b0 || Stall !== 1'b1 || HWrite !== 1'b0) begin fails++; $display("FAIL wait_done got req=%b stall=%b wr=%b want 0 1 0", HRequest, Stall, HWrite); end
    @(negedge clk); #1;
    tests++; if (HRequest !== 1'b0 || Stall !== 1'b1) begin fails++; $display("FAIL wait_idle_rearm got req=%b stall=%b want 0 1", HRequest, Stall); end
    Hit = 1'b1; MemRE = 1'b0; Dirty = 1'b0;
    @(negedge clk); #1;
    tests++; if (HRequest !== 1'b0 || Stall !== 1'b0) begin fails++; $display("FAIL wait_quiet got req=%b stall=%b want 0 0", HRequest, Stall); end
  endtask

  task automatic test_reset_mid_fetch();
    @(negedge clk); MemRE = 1'b1; Hit = 1'b0; Dirty = 1'b0; A = 32'h0000_4000; HREADY = 1'b1;
    @(negedge clk);
    @(negedge clk); #1;
    tests++; if (Counter !== 2'd1 || HRequest !== 1'b1) begin fails++; $display("FAIL rmid_w1 got cnt=%0d req=%b want 1 1", Counter, HRequest); end
    reset_n = 1'b0; #1;
    tests++; if (HRequest !== 1'b0 || Stall !== 1'b0 || Counter !== 2'd0 || BlockWE !== 1'b0) begin
      fails++; $display("FAIL rmid_async got req=%b stall=%b cnt=%0d we=%b want 0 0 0 0", HRequest, Stall, Counter, BlockWE); end
    @(negedge clk); #1;
    tests++; if (HRequest !== 1'b0 || BlockWE !== 1'b0 || Counter !== 2'd0) begin fails++; $display("FAIL rmid_held got req=%b we=%b cnt=%0d want 0 0 0", HRequest, BlockWE, Counter); end
    Hit = 1'b1; reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      tests++;
      if (HRequest !== 1'b0 || Stall !== 1'b0 || Counter !== 2'd0) begin
        fails++; $display("FAIL rmid_after%0d got req=%b stall=%b cnt=%0d want 0 0 0", k, HRequest, Stall, Counter);
      end
    end
    MemRE = 1'b0;
  endtask

  task automatic test_hit();
    @(negedge clk); MemRE = 1'b0; MemWriteM = 1'b1; Hit = 1'b1; Dirty = 1'b1; A = 32'h0000_5557;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      tests++;
      if (Stall !== 1'b0 || HRequest !== 1'b0 || BlockWE !== 1'b0 || HAddr !== 32'h5554) begin
        fails++; $display("FAIL hit%0d got stall=%b req=%b we=%b addr=%h want 0 0 0 00005554", k, Stall, HRequest, BlockWE, HAddr);
      end
    end
    MemWriteM = 1'b0;
  endtask

  initial begin
    test_reset();
    test_clean_miss();
    test_dirty_miss();
    test_wait_states();
    test_reset_mid_fetch();
    test_hit();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
